sram_responder: RTL and testbench
=================================

SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 SHALL provide parameter ADDR_W, default 10, meaning word-address bits used (depth 2^ADDR_W x 16).
REQ-002 SHALL provide parameter READ_WAIT, default 1, meaning OE cycles before read data is loaded (range 1..7).
REQ-003 SHALL provide parameter WRITE_WAIT, default 1, meaning WE cycles before the write commits (range 1..7).
REQ-004 Clk  input  1  sole clock, all state updates on its rising edge.
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 Mem_OE  input  1  read strobe from control unit, active-high, held for the whole access.
REQ-007 Mem_WE  input  1  write strobe from control unit, active-high, held for the whole access.
REQ-008 ADDR  input  16  word address (from MAR).
REQ-009 Data_from_CPU  input  16  write data (from MDR).
REQ-010 Data_to_CPU  output  16  registered read data.
REQ-011 Ready  output  1  high while the current access has completed and its strobe is still held.
REQ-012 Conflict  output  1  one-cycle pulse when OE and WE are both seen high in IDLE.

Function
REQ-013 States: IDLE, READ, READ_DONE, WRITE, WRITE_DONE; 3-bit wait counter cnt.
REQ-014 IDLE: WE=1 -> capture ADDR[ADDR_W-1:0] and Data_from_CPU, cnt=1, go WRITE; else OE=1 -> capture address, cnt=1, go READ; else stay.
REQ-015 OE and WE both high in IDLE: WE wins, Conflict=1 for that cycle only.
REQ-016 ADDR bits above ADDR_W-1 SHALL be ignored (address wraps modulo depth); no error.
REQ-017 READ: while OE=1 and cnt<READ_WAIT, cnt++; when cnt==READ_WAIT, Data_to_CPU loads mem[captured addr] at that edge, go READ_DONE.
REQ-018 Read latency: with OE rising in cycle 1, Data_to_CPU valid and Ready=1 in cycle READ_WAIT+1 (cycle 2 at default), matching a control unit that latches MDR on the second OE cycle.
REQ-019 WRITE: while WE=1 and cnt<WRITE_WAIT, cnt++; when cnt==WRITE_WAIT, mem[captured addr] <= captured data at that edge, go WRITE_DONE.
REQ-020 Ready=1 in READ_DONE and WRITE_DONE only; 0 elsewhere.
REQ-021 DONE states: stay while the owning strobe stays high (no repeat access); return to IDLE on the edge the strobe is seen low, so a new access needs at least one strobe-low cycle.
REQ-022 Strobe dropped in READ/WRITE before completion: abort to IDLE, no memory write, Data_to_CPU unchanged.
REQ-023 ADDR/Data_from_CPU changes after capture SHALL have no effect on the access in progress.
REQ-024 Data_to_CPU SHALL hold the last completed read value until the next read completes.
REQ-025 Strobe opposite to the one being serviced during READ/WRITE/DONE SHALL be ignored.

Reset
REQ-026 Reset=1 SHALL force IDLE, cnt=0, Data_to_CPU=16'h0000, Ready=0, Conflict=0 immediately, independent of Clk.
REQ-027 Reset SHALL NOT clear memory contents; a write interrupted by reset before its commit edge SHALL not occur.
REQ-028 After Reset falls, a strobe already held high SHALL start a fresh access on the next edge.

Structure
REQ-029 Package sram_responder_pkg SHALL hold the state enum type, data width constant (16) and counter width constant (3).
REQ-030 Storage SHALL be a sub-module sram_array: single-port synchronous write, combinational read, no reset; controller FSM stays in sram_responder.

Verification
REQ-031 Write then read, defaults: WE 2 cycles, ADDR=16'h0005, data 16'hBEEF; then OE 2 cycles same address -> Ready in cycle 2 of each, Data_to_CPU=16'hBEEF in read cycle 2.
REQ-032 Aborted write: mem[3]=16'h1234, WE high 1 cycle with data 16'hFFFF then low -> read of address 3 returns 16'h1234, Ready never high during write.
REQ-033 Conflict: OE and WE high together at ADDR=7, data 16'h00A5 -> Conflict pulse 1 cycle, write commits, later read returns 16'h00A5.
REQ-034 Wrap: ADDR_W=10, write 16'hCAFE to 16'h0402 -> read of 16'h0002 returns 16'hCAFE.
REQ-035 Reset mid-read: OE high, Reset asserted between cycles 1 and 2 -> Ready=0, Data_to_CPU=16'h0000 immediately, state IDLE; next OE read completes normally.
REQ-036 Long strobe and latency: READ_WAIT=3, OE held 6 cycles -> Ready cycles 4-6, single array read, IDLE one cycle after OE falls.

Source files
------------

// File: rtl/sram_responder_pkg.sv
// rtl/sram_responder_pkg.sv - shared types and widths for the SRAM responder
package sram_responder_pkg;

    localparam int DATA_W = 16;
    localparam int CNT_W  = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_READ_DONE,
        ST_WRITE,
        ST_WRITE_DONE
    } state_e;

endpackage

// File: rtl/sram_array.sv
// rtl/sram_array.sv - single-port storage: synchronous write, combinational read, no reset
module sram_array
    import sram_responder_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/sram_responder.sv
// rtl/sram_responder.sv - strobe-driven SRAM responder with programmable read/write wait
module sram_responder
    import sram_responder_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int READ_WAIT  = 1,
    parameter int WRITE_WAIT = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Mem_OE,
    input  logic              Mem_WE,
    input  logic [DATA_W-1:0] ADDR,
    input  logic [DATA_W-1:0] Data_from_CPU,
    output logic [DATA_W-1:0] Data_to_CPU,
    output logic              Ready,
    output logic              Conflict
);

    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(READ_WAIT);
    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WRITE_WAIT);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [DATA_W-1:0]  rdata_q;
    logic               ready_q;
    logic               conflict_q;
    logic [DATA_W-1:0]  arr_rdata;
    logic               mem_we;
    logic               unused_addr_hi;

    // Upper address bits are intentionally dropped so the address wraps modulo depth.
    assign unused_addr_hi = ^ADDR;

    // Commit only on the edge where the strobe is still held and the wait has elapsed.
    assign mem_we = (state_q == ST_WRITE) && Mem_WE && (cnt_q == WR_LAST);

    sram_array #(.ADDR_W(ADDR_W)) u_array (
        .clk_i   (Clk),
        .we_i    (mem_we),
        .addr_i  (addr_q),
        .wdata_i (wdata_q),
        .rdata_o (arr_rdata)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            ready_q    <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            conflict_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    ready_q <= 1'b0;
                    if (Mem_WE) begin
                        addr_q     <= ADDR[ADDR_W-1:0];
                        wdata_q    <= Data_from_CPU;
                        cnt_q      <= CNT_W'(1);
                        conflict_q <= Mem_OE;
                        state_q    <= ST_WRITE;
                    end else if (Mem_OE) begin
                        addr_q  <= ADDR[ADDR_W-1:0];
                        cnt_q   <= CNT_W'(1);
                        state_q <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (!Mem_OE) begin
                        state_q <= ST_IDLE;
                    end else if (cnt_q == RD_LAST) begin
                        rdata_q <= arr_rdata;
                        ready_q <= 1'b1;
                        state_q <= ST_READ_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_READ_DONE: begin
                    if (!Mem_OE) begin
                        ready_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    if (!Mem_WE) begin
                        state_q <= ST_IDLE;
                    end else if (cnt_q == WR_LAST) begin
                        ready_q <= 1'b1;
                        state_q <= ST_WRITE_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_WRITE_DONE: begin
                    if (!Mem_WE) begin
                        ready_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    ready_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign Data_to_CPU = rdata_q;
    assign Ready       = ready_q;
    assign Conflict    = conflict_q;

endmodule

// File: tb/tb_sram_responder.sv
// tb/tb_sram_responder.sv - randomized transaction-level check of two responder configurations
module tb_sram_responder;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Mem_OE, Mem_WE;
    logic [15:0] ADDR, Data_from_CPU;
    logic [15:0] d0, d1;
    logic        r0, r1, c0, c1;

    always #5 Clk = ~Clk;

    sram_responder #(.ADDR_W(10), .READ_WAIT(1), .WRITE_WAIT(1)) dut0 (
        .Clk(Clk), .Reset(Reset), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
        .ADDR(ADDR), .Data_from_CPU(Data_from_CPU),
        .Data_to_CPU(d0), .Ready(r0), .Conflict(c0)
    );

    sram_responder #(.ADDR_W(10), .READ_WAIT(3), .WRITE_WAIT(2)) dut1 (
        .Clk(Clk), .Reset(Reset), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
        .ADDR(ADDR), .Data_from_CPU(Data_from_CPU),
        .Data_to_CPU(d1), .Ready(r1), .Conflict(c1)
    );

    int          rwait [2] = '{1, 3};
    int          wwait [2] = '{1, 2};
    logic [15:0] mem_m [2][1024];
    logic [15:0] dexp  [2];
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] out_d(input int k);
        return (k == 0) ? d0 : d1;
    endfunction

    function automatic logic out_r(input int k);
        return (k == 0) ? r0 : r1;
    endfunction

    function automatic logic out_c(input int k);
        return (k == 0) ? c0 : c1;
    endfunction

    task automatic check_outputs(input string tag, input bit [1:0] exp_rdy, input bit exp_cfl);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s.rdy%0d", tag, k), 16'(out_r(k)), 16'(exp_rdy[k]));
            check($sformatf("%s.cfl%0d", tag, k), 16'(out_c(k)), 16'(exp_cfl));
            check($sformatf("%s.dat%0d", tag, k), out_d(k), dexp[k]);
        end
    endtask

    task automatic idle(input int n);
        Mem_OE = 1'b0;
        Mem_WE = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge Clk); #1;
            check_outputs("idle", 2'b00, 1'b0);
        end
    endtask

    // One access: primary strobe held for len sampled edges, then both low for one edge.
    task automatic do_access(input bit wr, input int len, input bit cflt,
                             input logic [15:0] addr, input logic [15:0] data, input string tag);
        int       idx;
        int       w;
        bit [1:0] er;
        idx           = int'(addr) % 1024;
        Mem_WE        = wr;
        Mem_OE        = !wr || cflt;
        ADDR          = addr;
        Data_from_CPU = data;
        for (int j = 1; j <= len + 1; j++) begin
            @(posedge Clk); #1;
            for (int k = 0; k < 2; k++) begin
                w     = wr ? wwait[k] : rwait[k];
                er[k] = (j >= w + 1) && (j <= len);
                if (j == w + 1 && len >= w + 1) begin
                    if (wr) mem_m[k][idx] = data;
                    else    dexp[k] = mem_m[k][idx];
                end
            end
            check_outputs($sformatf("%s.c%0d", tag, j), er, (j == 1) && cflt && wr);
            if (j < len) begin
                ADDR          = 16'($urandom);
                Data_from_CPU = 16'($urandom);
                if (wr) Mem_OE = 1'($urandom % 2);
                else    Mem_WE = 1'($urandom % 2);
            end else begin
                Mem_OE = 1'b0;
                Mem_WE = 1'b0;
            end
        end
    endtask

    task automatic reset_mid(input bit wr, input logic [15:0] addr, input logic [15:0] data);
        Mem_WE        = wr;
        Mem_OE        = !wr;
        ADDR          = addr;
        Data_from_CPU = data;
        @(posedge Clk); #1;
        check_outputs("rst_mid.c1", 2'b00, 1'b0);
        #2 Reset = 1'b1;
        #1;
        dexp[0] = 16'h0000;
        dexp[1] = 16'h0000;
        check_outputs("rst_mid.async", 2'b00, 1'b0);
        #1 Reset = 1'b0;
        if (wr) Mem_WE = 1'b0;
    endtask

    initial begin
        Reset         = 1'b1;
        Mem_OE        = 1'b0;
        Mem_WE        = 1'b0;
        ADDR          = '0;
        Data_from_CPU = '0;
        dexp[0]       = 16'h0000;
        dexp[1]       = 16'h0000;
        #12;
        check_outputs("reset", 2'b00, 1'b0);
        @(posedge Clk); #1;
        Reset = 1'b0;

        for (int a = 0; a < 16; a++) do_access(1'b1, 4, 1'b0, 16'(a), 16'($urandom), "init");

        do_access(1'b1, 2, 1'b0, 16'h0005, 16'hBEEF, "w5");
        do_access(1'b0, 2, 1'b0, 16'h0005, 16'h0000, "r5");
        check("beef", d0, 16'hBEEF);

        do_access(1'b1, 4, 1'b0, 16'h0003, 16'h1234, "w3");
        do_access(1'b1, 1, 1'b0, 16'h0003, 16'hFFFF, "w3abort");
        do_access(1'b0, 6, 1'b0, 16'h0003, 16'h0000, "r3long");
        check("abort0", d0, 16'h1234);
        check("abort1", d1, 16'h1234);

        do_access(1'b1, 3, 1'b1, 16'h0007, 16'h00A5, "conflict");
        do_access(1'b0, 4, 1'b0, 16'h0007, 16'h0000, "r7");
        check("conflict0", d0, 16'h00A5);
        check("conflict1", d1, 16'h00A5);

        do_access(1'b1, 3, 1'b0, 16'h0402, 16'hCAFE, "wwrap");
        do_access(1'b0, 4, 1'b0, 16'h0002, 16'h0000, "rwrap");
        check("wrap0", d0, 16'hCAFE);
        check("wrap1", d1, 16'hCAFE);

        reset_mid(1'b0, 16'h0005, 16'h0000);
        do_access(1'b0, 4, 1'b0, 16'h0005, 16'h0000, "rafter_rst");

        reset_mid(1'b1, 16'h0009, 16'hFFFF);
        idle(1);
        do_access(1'b0, 4, 1'b0, 16'h0009, 16'h0000, "rst_wr_chk");

        for (int n = 0; n < 200; n++) begin
            bit wr;
            wr = 1'($urandom % 2);
            do_access(wr, int'($urandom_range(1, 7)), wr & 1'($urandom % 2),
                      16'($urandom) & 16'hFC0F, 16'($urandom), "rand");
            if ($urandom % 3 == 0) idle(int'($urandom_range(1, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
